mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences the memory stage's single data-bus transaction for loads and stores on the 64-bit dbus.
- Latches the request, holds the dbus request stable until the bus responds, and generates byte strobes and aligned write data.
- Formats load data with shift and sign/zero extension.
- Stalls the pipeline until the access completes, then holds the result while downstream is frozen. Sits between the execute/memory pipeline register and the dbus port.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width; strobe width is DATA_W/8

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  memory-stage instruction performs a load/store
req_write  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=double
req_unsigned  in  1  load zero-extends when 1
req_addr  in  64  effective address (ALU result)
req_wdata  in  64  store data (rs2), LSB-justified
stall_in  in  1  downstream/global freeze; pipeline cannot advance
dreq_valid  out  1  dbus request valid
dreq_addr  out  64  dbus address (registered req_addr)
dreq_size  out  2  dbus size (registered req_size)
dreq_strobe  out  8  byte-write enables; 0 for loads
dreq_data  out  64  lane-aligned store data
dresp_addr_ok  in  1  bus accepted address (informational only)
dresp_data_ok  in  1  bus completed transaction
dresp_data  in  64  raw 64-bit read data
rdata  out  64  formatted load result
done  out  1  access complete, rdata valid
stall_out  out  1  memory stage not ready; freeze upstream
misalign  out  1  request misaligned, no bus access issued

Behaviour:
- Reset (async, any state): state=IDLE. All dreq_* = 0, rdata = 0, done = 0, stall_out = 0, misalign = 0.
- Alignment check (combinational, IDLE only):
  - misalign = req_valid & (half & addr[0] | word & addr[1:0]≠0 | double & addr[2:0]≠0).
  - A misaligned request issues no bus access; stall_out = 0, done = 0.
- FSM states: IDLE, BUSY, HOLD.
- IDLE:
  - On req_valid & !misalign, register addr, size, write, unsigned, wdata; go to BUSY.
  - stall_out = 1 in that cycle.
  - Otherwise stay in IDLE; stall_out = 0.
- BUSY:
  - dreq_valid = 1. dreq_addr, size, strobe and data come from registers and stay constant until data_ok.
  - stall_out = 1.
  - On dresp_data_ok, capture formatted data into rdata and go to HOLD.
  - dresp_addr_ok has no effect on state.
- HOLD:
  - dreq_valid = 0, done = 1, stall_out = 0, rdata held.
  - If stall_in = 1, stay in HOLD; otherwise go to IDLE at the next edge (instruction advances on that edge).
- Latency: minimum 3 cycles from accept to done (IDLE → BUSY with data_ok in the first BUSY cycle → HOLD). No back-to-back accept from HOLD.
- Store data uses off = addr[2:0]:
  - Strobe: byte = 8'h01<<off, half = 8'h03<<off, word = 8'h0F<<off, double = 8'hFF.
  - dreq_data = wdata << (8*off), upper bits truncated.
- Loads: strobe = 0, dreq_data = 0.
- Load formatting:
  - sh = dresp_data >> (8*off).
  - Take the low 8/16/32/64 bits by size; sign-extend unless unsigned.
  - Double ignores unsigned.
  - Stores write rdata = 0.
- Input changes: req_* changes while BUSY/HOLD are ignored because the request is registered.
- Reset asserted mid-BUSY drops dreq_valid the same cycle. A late data_ok after reset is ignored (IDLE ignores dresp).
- If req_valid is deasserted while BUSY (illegal upstream), the transaction still completes.

Test Plan:
- Load byte signed: addr=0x80000003, dresp_data=0x00000000_80FF0000 with data_ok 2 cycles after BUSY entry → rdata=0xFFFF_FFFF_FFFF_FF80, done for 1 cycle, dreq stable throughout BUSY.
- Store half: addr=0x1006, wdata=0xABCD → strobe=0xC0, dreq_data=0xABCD_0000_0000_0000, stall_out=1 until the data_ok edge, then done=1.
- Misaligned word: addr=0x1002, size=2 → misalign=1, dreq_valid never 1, stall_out=0.
- HOLD under stall: data_ok arrives with stall_in=1 for 3 cycles → done=1 and rdata constant for 4 cycles, then return to IDLE.
- Unsigned word load: addr=0x2004, dresp_data=0x8000_0001_xxxx_xxxx → rdata=0x0000_0000_8000_0001; the same load signed gives 0xFFFF_FFFF_8000_0001.
- Async reset mid-BUSY: dreq_valid=0 immediately. data_ok pulsed afterwards → state stays IDLE, done=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one dbus load/store per memory-stage instruction,
// holding the request until data_ok and freezing upstream until the result is consumed.
module mem_access_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic                  stall_in,
    output logic                  dreq_valid,
    output logic [ADDR_W-1:0]     dreq_addr,
    output logic [1:0]            dreq_size,
    output logic [DATA_W/8-1:0]   dreq_strobe,
    output logic [DATA_W-1:0]     dreq_data,
    input  logic                  dresp_addr_ok,
    input  logic                  dresp_data_ok,
    input  logic [DATA_W-1:0]     dresp_data,
    output logic [DATA_W-1:0]     rdata,
    output logic                  done,
    output logic                  stall_out,
    output logic                  misalign
);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                write_q;
    logic                unsigned_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   rdata_d;
    logic [DATA_W-1:0]   sh;
    logic [7:0]          base;
    logic [2:0]          amask;
    logic [2:0]          off;
    logic                sx;
    logic                accept;
    logic                unused_addr_ok;

    // address accept is informational; completion is signalled only by data_ok
    assign unused_addr_ok = dresp_addr_ok;

    assign amask    = req_size == 2'd0 ? 3'd0 : req_size == 2'd1 ? 3'd1 : req_size == 2'd2 ? 3'd3 : 3'd7;
    assign misalign = (state_q == IDLE) & req_valid & |(req_addr[2:0] & amask);
    assign accept   = (state_q == IDLE) & req_valid & ~misalign;

    assign off  = addr_q[2:0];
    assign base = size_q == 2'd0 ? 8'h01 : size_q == 2'd1 ? 8'h03 : size_q == 2'd2 ? 8'h0F : 8'hFF;
    assign sx   = ~unsigned_q;
    assign sh   = dresp_data >> {off, 3'b000};

    always_comb begin
        rdata_d = size_q == 2'd0 ? {{(DATA_W-8){sx & sh[7]}}, sh[7:0]} :
                  size_q == 2'd1 ? {{(DATA_W-16){sx & sh[15]}}, sh[15:0]} :
                  size_q == 2'd2 ? {{(DATA_W-32){sx & sh[31]}}, sh[31:0]} : sh;
    end

    assign dreq_valid  = state_q == BUSY;
    assign dreq_addr   = addr_q;
    assign dreq_size   = size_q;
    assign dreq_strobe = write_q ? base << off : '0;
    assign dreq_data   = write_q ? wdata_q << {off, 3'b000} : '0;
    assign rdata       = rdata_q;
    assign done        = state_q == HOLD;
    assign stall_out   = accept | (state_q == BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    addr_q     <= req_addr;
                    size_q     <= req_size;
                    write_q    <= req_write;
                    unsigned_q <= req_unsigned;
                    wdata_q    <= req_wdata;
                    state_q    <= BUSY;
                end
                BUSY: if (dresp_data_ok) begin
                    rdata_q <= write_q ? '0 : rdata_d;
                    state_q <= HOLD;
                end
                HOLD: if (!stall_in) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors with hand-computed expectations for mem_access_ctrl.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        stall_in = 1'b0;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;
    logic [63:0] dresp_data = '0;
    logic [63:0] rdata;
    logic        done, stall_out, misalign;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall_in(stall_in),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .rdata(rdata), .done(done), .stall_out(stall_out), .misalign(misalign)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic u, input logic [63:0] a, input logic [63:0] wd);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, rdata, done, stall_out, misalign} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%0b addr=%h strobe=%h data=%h rdata=%h done=%0b stall=%0b mis=%0b, want all 0",
                     dreq_valid, dreq_addr, dreq_strobe, dreq_data, rdata, done, stall_out, misalign);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_load_byte();
        drive(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0);
        #1;
        vectors++;
        if (stall_out !== 1'b1 || dreq_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lb_accept: got stall=%0b valid=%0b, want 1 0", stall_out, dreq_valid);
        end
        step();
        req_valid = 1'b0; req_addr = 64'hDEAD_BEE0; req_size = 2'd3;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin dresp_data_ok = 1'b1; dresp_data = 64'h0000_0000_80FF_0000; end
            #1;
            vectors++;
            if (dreq_valid !== 1'b1 || dreq_addr !== 64'h8000_0003 || dreq_size !== 2'd0 ||
                dreq_strobe !== 8'h00 || dreq_data !== 64'h0 || stall_out !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL lb_busy%0d: got valid=%0b addr=%h size=%0d strobe=%h data=%h stall=%0b done=%0b, want 1 80000003 0 00 0 1 0",
                         i, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, stall_out, done);
            end
            step();
        end
        dresp_data_ok = 1'b0;
        vectors++;
        if (done !== 1'b1 || rdata !== 64'hFFFF_FFFF_FFFF_FF80 || dreq_valid !== 1'b0 || stall_out !== 1'b0) begin
            miscompares++;
            $display("FAIL lb_hold: got done=%0b rdata=%h valid=%0b stall=%0b, want 1 ffffffffffffff80 0 0",
                     done, rdata, dreq_valid, stall_out);
        end
        step();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL lb_done_pulse: got done=%0b, want 0", done);
        end
    endtask

    task automatic test_store_half();
        drive(1'b1, 2'd1, 1'b0, 64'h1006, 64'hABCD);
        step();
        req_valid = 1'b0;
        vectors++;
        if (dreq_valid !== 1'b1 || dreq_strobe !== 8'hC0 || dreq_data !== 64'hABCD_0000_0000_0000 || stall_out !== 1'b1) begin
            miscompares++;
            $display("FAIL sh_busy: got valid=%0b strobe=%h data=%h stall=%0b, want 1 c0 abcd000000000000 1",
                     dreq_valid, dreq_strobe, dreq_data, stall_out);
        end
        dresp_data_ok = 1'b1; dresp_data = 64'h1234_5678_9ABC_DEF0;
        step();
        dresp_data_ok = 1'b0;
        vectors++;
        if (done !== 1'b1 || stall_out !== 1'b0 || rdata !== 64'h0) begin
            miscompares++;
            $display("FAIL sh_hold: got done=%0b stall=%0b rdata=%h, want 1 0 0", done, stall_out, rdata);
        end
        step();
    endtask

    task automatic test_misalign();
        logic [1:0]  sz[4] = '{2'd2, 2'd3, 2'd1, 2'd0};
        logic [63:0] ad[4] = '{64'h1002, 64'h1004, 64'h1001, 64'h1007};
        logic        ex[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, sz[i], 1'b0, ad[i], 64'h0);
            for (int c = 0; c < 2; c++) begin
                #1;
                vectors++;
                if (misalign !== ex[i] || stall_out !== 1'b0 || dreq_valid !== 1'b0 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL misalign%0d_c%0d: got mis=%0b stall=%0b valid=%0b done=%0b, want %0b 0 0 0",
                             i, c, misalign, stall_out, dreq_valid, done, ex[i]);
                end
                step();
            end
        end
        drive(1'b0, sz[3], 1'b0, ad[3], 64'h0);
        #1;
        vectors++;
        if (misalign !== 1'b0 || stall_out !== 1'b1) begin
            miscompares++;
            $display("FAIL byte_odd_aligned: got mis=%0b stall=%0b, want 0 1", misalign, stall_out);
        end
        step();
        req_valid = 1'b0;
        dresp_data_ok = 1'b1; dresp_data = 64'hAA00_0000_0000_0000;
        step();
        dresp_data_ok = 1'b0;
        vectors++;
        if (rdata !== 64'hFFFF_FFFF_FFFF_FFAA) begin
            miscompares++;
            $display("FAIL byte_top_lane: got %h, want ffffffffffffffaa", rdata);
        end
        step();
    endtask

    task automatic test_hold_stall();
        logic [63:0] want = 64'h0123_4567_89AB_CDEF;
        drive(1'b0, 2'd3, 1'b1, 64'h3000, 64'h0);
        step();
        req_valid = 1'b0;
        dresp_data_ok = 1'b1; dresp_data = want; stall_in = 1'b1;
        step();
        dresp_data_ok = 1'b0; dresp_data = 64'h0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (done !== 1'b1 || rdata !== want || stall_out !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_stall%0d: got done=%0b rdata=%h stall=%0b, want 1 %h 0", i, done, rdata, stall_out, want);
            end
            if (i == 3) stall_in = 1'b0;
            step();
        end
        vectors++;
        if (done !== 1'b0 || stall_out !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release: got done=%0b stall=%0b, want 0 0", done, stall_out);
        end
    endtask

    task automatic test_word_ext();
        logic        u[2] = '{1'b1, 1'b0};
        logic [63:0] want[2] = '{64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001};
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'd2, u[i], 64'h2004, 64'h0);
            step();
            req_valid = 1'b0;
            dresp_data_ok = 1'b1; dresp_data = 64'h8000_0001_1357_9BDF;
            step();
            dresp_data_ok = 1'b0;
            vectors++;
            if (rdata !== want[i] || done !== 1'b1) begin
                miscompares++;
                $display("FAIL word_ext_u%0b: got rdata=%h done=%0b, want %h 1", u[i], rdata, done, want[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 2'd1, 1'b0, 64'h4002, 64'h0);
        step();
        dresp_data_ok = 1'b1; dresp_data = 64'h0000_0000_7FFE_0000;
        step();
        dresp_data_ok = 1'b0;
        vectors++;
        if (done !== 1'b1 || stall_out !== 1'b0 || rdata !== 64'h7FFE) begin
            miscompares++;
            $display("FAIL b2b_hold: got done=%0b stall=%0b rdata=%h, want 1 0 7ffe", done, stall_out, rdata);
        end
        step();
        vectors++;
        if (done !== 1'b0 || stall_out !== 1'b1 || dreq_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_reaccept: got done=%0b stall=%0b valid=%0b, want 0 1 0", done, stall_out, dreq_valid);
        end
        step();
        req_valid = 1'b0;
        dresp_data_ok = 1'b1;
        step();
        dresp_data_ok = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'd2, 1'b0, 64'h5008, 64'hCAFE_F00D);
        step();
        req_valid = 1'b0;
        vectors++;
        if (dreq_valid !== 1'b1 || dreq_strobe !== 8'h0F) begin
            miscompares++;
            $display("FAIL ar_busy: got valid=%0b strobe=%h, want 1 0f", dreq_valid, dreq_strobe);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (dreq_valid !== 1'b0 || stall_out !== 1'b0 || dreq_addr !== 64'h0 || dreq_strobe !== 8'h0) begin
            miscompares++;
            $display("FAIL ar_drop: got valid=%0b stall=%0b addr=%h strobe=%h, want 0 0 0 0", dreq_valid, stall_out, dreq_addr, dreq_strobe);
        end
        #1 reset = 1'b0;
        dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        dresp_data_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (done !== 1'b0 || dreq_valid !== 1'b0 || rdata !== 64'h0) begin
                miscompares++;
                $display("FAIL ar_late_ok%0d: got done=%0b valid=%0b rdata=%h, want 0 0 0", i, done, dreq_valid, rdata);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_hold_stall();
        test_word_ext();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
